// File: rtl/kernel_pkg.sv
// kernel_pkg: shared definitions for the CU 3x3 Gaussian kernel path.
//   DATA_W      - sample/result width
//   KTAPS       - samples per 3x3 window
//   KNORM_SHIFT - normalisation shift (total kernel weight is 16)
//   tap_shift() - weight of a raster-order tap expressed as a left shift
//   kstate_t    - window collection FSM states
package kernel_pkg;

  localparam int DATA_W      = 16;
  localparam int KTAPS       = 9;
  localparam int KNORM_SHIFT = 4;

  typedef enum logic [1:0] {
    K_IDLE,
    K_ACCUM,
    K_DONE
  } kstate_t;

  // Weights 1 2 1 / 2 4 2 / 1 2 1 in raster order: corners x1, edges x2,
  // centre x4.
  function automatic logic [1:0] tap_shift(input logic [3:0] tap);
    case (tap)
      4'd4:                    return 2'd2;
      4'd1, 4'd3, 4'd5, 4'd7:  return 2'd1;
      default:                 return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/kernel_accum.sv
// kernel_accum: collects one 3x3 window of unsigned samples in raster order,
// forms the Gaussian-weighted sum (1 2 1 / 2 4 2 / 1 2 1), normalises it by 16
// and emits one down-sampled pixel per window.
//
// Optional feature: define KERNEL_ROUND_EN to round half-up when normalising;
// otherwise the result is truncated. Latency is identical in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   sample valid
//   in_ready   block can accept a sample
//   in_data    unsigned sample
//   in_last    marks the 9th sample of the window (checked, not used to count)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   normalised weighted sum
//   err_frame  sticky flag: in_last did not line up with the 9th sample
//   clr        synchronous abort of the current window
module kernel_accum
  import kernel_pkg::*;
#(
  parameter int DATA_W = kernel_pkg::DATA_W,
  parameter int ACC_W  = DATA_W + 4,
  parameter int TAPS   = KTAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_frame,
  input  logic              clr
);

  kstate_t          state, state_nx;
  logic [3:0]       tap_p0;
  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W-1:0] acc_sum;
  logic             accept;
  logic             last_tap;
  logic             out_hs;

  function automatic logic [DATA_W-1:0] norm(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
`ifdef KERNEL_ROUND_EN
    r = a + (ACC_W'(1) << (KNORM_SHIFT - 1));
`else
    r = a;
`endif
    return r[ACC_W-1:KNORM_SHIFT];
  endfunction

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  assign in_ready  = rst_n && (state != K_DONE);
  assign out_valid = (state == K_DONE);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_tap  = (tap_p0 == 4'(TAPS - 1));
  assign acc_sum   = acc_p0 + (ACC_W'(in_data) << tap_shift(tap_p0));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= K_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      K_IDLE:  if (accept)             state_nx = K_ACCUM;
      K_ACCUM: if (accept && last_tap) state_nx = K_DONE;
      K_DONE:  if (out_hs)             state_nx = K_IDLE;
      default:                         state_nx = K_IDLE;
    endcase
    if (clr) state_nx = K_IDLE;
  end

  // Stage p0: accumulate; the 9th accept also registers the normalised result
  // so it appears with out_valid one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_p0    <= '0;
      acc_p0    <= '0;
      out_data  <= '0;
      err_frame <= 1'b0;
    end else if (clr) begin
      tap_p0 <= '0;
      acc_p0 <= '0;
    end else begin
      if (accept) begin
        // Framing errors are only flagged; counting always closes on tap 8.
        if (in_last != last_tap) err_frame <= 1'b1;
        acc_p0 <= acc_sum;
        if (last_tap) begin
          tap_p0   <= '0;
          out_data <= norm(acc_sum);
        end else begin
          tap_p0 <= tap_p0 + 4'd1;
        end
      end
      if (out_hs) acc_p0 <= '0;
    end
  end

endmodule

// File: tb/tb_kernel_accum.sv
module tb_kernel_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        err_frame;
  logic        clr;

  int total = 0;
  int bad   = 0;

  logic [15:0] win [9];
  logic [15:0] exp_center;

  always #5 clk = ~clk;

  kernel_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_frame (err_frame),
    .clr       (clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_win();
    for (int i = 0; i < 9; i++) send(win[i], i == 8);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 9; i++) win[i] = v;
  endtask

  initial begin
`ifdef KERNEL_ROUND_EN
    exp_center = 16'd1;
`else
    exp_center = 16'd0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; clr = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_err", err_frame, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    step();

    // All 16 -> 256/16 = 16
    fill(16'd16);
    send_win();
    chk("flat16_valid", out_valid, 1'b1);
    chk("flat16_data", out_data, 16'd16);
    chk("flat16_in_ready", in_ready, 1'b0);
    chk("flat16_err", err_frame, 1'b0);
    step();
    chk("flat16_hs_valid", out_valid, 1'b0);
    chk("flat16_hs_in_ready", in_ready, 1'b1);
    chk("flat16_hold_data", out_data, 16'd16);

    // Ramp 1..9 -> weighted sum 80 -> 5 in both modes
    for (int i = 0; i < 9; i++) win[i] = 16'(i + 1);
    send_win();
    chk("ramp_valid", out_valid, 1'b1);
    chk("ramp_data", out_data, 16'd5);
    step();

    // Centre only = 3 -> sum 12 -> 0 truncated, 1 rounded
    fill(16'd0);
    win[4] = 16'd3;
    send_win();
    chk("center_data", out_data, exp_center);
    step();

    // All 0xFFFF with consumer stalled for 5 cycles
    out_ready = 1'b0;
    fill(16'hFFFF);
    send_win();
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 16'hFFFF);
      chk("stall_in_ready", in_ready, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_release_valid", out_valid, 1'b0);
    chk("stall_release_in_ready", in_ready, 1'b1);

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 4; i++) send(16'd500, 1'b0);
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    fill(16'd32);
    send_win();
    chk("midrst_data", out_data, 16'd32);
    chk("midrst_valid", out_valid, 1'b1);
    step();

    // in_last on the 5th sample: sticky error, window still closes on 9th
    fill(16'd16);
    for (int i = 0; i < 4; i++) send(win[i], 1'b0);
    chk("err_before", err_frame, 1'b0);
    send(win[4], 1'b1);
    chk("err_set", err_frame, 1'b1);
    for (int i = 5; i < 9; i++) send(win[i], i == 8);
    chk("err_close_valid", out_valid, 1'b1);
    chk("err_close_data", out_data, 16'd16);
    step();
    chk("err_sticky", err_frame, 1'b1);

    // clr mid-window, with a simultaneous sample that must be ignored
    for (int i = 0; i < 4; i++) send(16'd500, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd1000;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    chk("clr_err_kept", err_frame, 1'b1);
    fill(16'd32);
    send_win();
    chk("clr_data", out_data, 16'd32);
    chk("clr_valid", out_valid, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
